// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// interrupt code constants and the pending-bit to code mapping.
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_t;

  localparam int CODE_NONE     = 0;
  localparam int CODE_TIMER    = 1;
  localparam int CODE_IRQ_BASE = 2;

  // Pending bit 0 is the timer; bit i+1 is external line i.
  function automatic int code_of_bit(input int bit_idx);
    return (bit_idx == 0) ? CODE_TIMER : CODE_IRQ_BASE + bit_idx - 1;
  endfunction

endpackage

// File: rtl/temporizador_quantum.sv
// Preemption quantum timer: armed by a user-mode entry, disarmed by a
// kernel-mode entry, and fires a one-cycle expire pulse when the counter
// reaches QUANTUM-1. Counting only advances while count_en is high.
module temporizador_quantum #(
  parameter int QUANTUM = 1000
) (
  input  logic clock,
  input  logic rst,
  input  logic user_mode,
  input  logic kernel_mode,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;

  logic [CNT_W-1:0] count_reg;
  logic             armed_reg;

  // The edge that would bring the count to QUANTUM-1 is the expiry edge;
  // a mode pulse in that cycle takes precedence and restarts/stops the timer.
  assign expire = armed_reg && count_en && !user_mode && !kernel_mode &&
                  (count_reg == CNT_W'(QUANTUM - 2));

  // Counter and armed flag; userMode beats kernelMode when both are high.
  always_ff @(posedge clock) begin
    if (!rst) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (user_mode) begin
      count_reg <= '0;
      armed_reg <= 1'b1;
    end else if (kernel_mode || expire) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (armed_reg && count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller, responder side of the control unit handshake.
// Collects sticky requests, raises intr with the highest-priority code,
// captures the PC on inta and holds code/PC until clearIntr.
// Optional build macro: TIMER_INTR_EN compiles in the quantum timer
// (pending bit 0, code 1); without it userMode/kernelMode are unused.
module controlador_de_interrupcao
  import intr_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int QUANTUM = 1000,
  parameter int DATA_W  = 32
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  irq,
  input  logic                userMode,
  input  logic                kernelMode,
  input  logic                inta,
  input  logic                clearIntr,
  input  logic [DATA_W-1:0]   pc,
  output logic                intr,
  output logic [DATA_W-1:0]   intrCode,
  output logic [DATA_W-1:0]   intrPc,
  output logic [NUM_SRC:0]    pending
);

  intr_state_t         state_reg;
  logic                intr_reg;
  logic [DATA_W-1:0]   code_reg;
  logic [DATA_W-1:0]   pc_reg;
  logic [NUM_SRC:0]    pending_reg;
  logic [NUM_SRC:0]    pending_next;
  logic [NUM_SRC:0]    clr_mask;
  logic [DATA_W-1:0]   best_code;
  logic                timer_expire;

  assign intr     = intr_reg;
  assign intrCode = code_reg;
  assign intrPc   = pc_reg;
  assign pending  = pending_reg;

`ifdef TIMER_INTR_EN
  temporizador_quantum #(
    .QUANTUM (QUANTUM)
  ) u_timer (
    .clock       (clock),
    .rst         (rst),
    .user_mode   (userMode),
    .kernel_mode (kernelMode),
    .count_en    (state_reg == ST_IDLE),
    .expire      (timer_expire)
  );
`else
  localparam int unused_quantum = QUANTUM;
  logic unused_timer;
  assign timer_expire = 1'b0;
  assign unused_timer = ^{userMode, kernelMode, clr_mask[0], timer_expire};
`endif

  // End of service clears only the bit belonging to the code in flight.
  genvar gi;
  generate
    for (gi = 0; gi <= NUM_SRC; gi++) begin : g_clr
      assign clr_mask[gi] = (state_reg == ST_SERVICE) && clearIntr &&
                            (code_reg == DATA_W'(code_of_bit(gi)));
    end
  endgenerate

  // Lowest pending index wins; scan downward so the last hit is the lowest.
  always_comb begin
    best_code = DATA_W'(CODE_NONE);
    for (int i = NUM_SRC; i >= 0; i--) begin
      if (pending_reg[i]) best_code = DATA_W'(code_of_bit(i));
    end
  end

  // Sticky pending: a request in the clearing cycle keeps the bit set.
  always_comb begin
    pending_next = '0;
    pending_next[NUM_SRC:1] = irq | (pending_reg[NUM_SRC:1] & ~clr_mask[NUM_SRC:1]);
`ifdef TIMER_INTR_EN
    pending_next[0] = timer_expire | (pending_reg[0] & ~clr_mask[0]);
`else
    pending_next[0] = 1'b0;
`endif
  end

  // Pending register update.
  always_ff @(posedge clock) begin
    if (!rst) pending_reg <= '0;
    else      pending_reg <= pending_next;
  end

  // Handshake FSM: raise request, capture PC on acknowledge, hold until cleared.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      intr_reg  <= 1'b0;
      code_reg  <= DATA_W'(CODE_NONE);
      pc_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|pending_reg) begin
            code_reg  <= best_code;
            intr_reg  <= 1'b1;
            state_reg <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (inta) begin
            pc_reg    <= pc;
            intr_reg  <= 1'b0;
            state_reg <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (clearIntr) begin
            code_reg  <= DATA_W'(CODE_NONE);
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          intr_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Directed bench for controlador_de_interrupcao; inta is tied to intr the
// way the control unit answers. Timer scenarios depend on TIMER_INTR_EN.
module tb_controlador_de_interrupcao;

  localparam int NSRC = 4;
  localparam int TQ   = 8;
  localparam int DW   = 32;

  logic            clock = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic            userMode;
  logic            kernelMode;
  logic            inta;
  logic            clearIntr;
  logic [DW-1:0]   pc;
  logic            intr;
  logic [DW-1:0]   intrCode;
  logic [DW-1:0]   intrPc;
  logic [NSRC:0]   pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign inta = intr;

  controlador_de_interrupcao #(
    .NUM_SRC (NSRC),
    .QUANTUM (TQ),
    .DATA_W  (DW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .irq        (irq),
    .userMode   (userMode),
    .kernelMode (kernelMode),
    .inta       (inta),
    .clearIntr  (clearIntr),
    .pc         (pc),
    .intr       (intr),
    .intrCode   (intrCode),
    .intrPc     (intrPc),
    .pending    (pending)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hits;
    rst = 1'b0; irq = '0; userMode = 1'b0; kernelMode = 1'b0;
    clearIntr = 1'b0; pc = 32'h40;
    tick(); tick();
    check("rst_intr", intr, 0);
    check("rst_code", intrCode, 0);
    check("rst_pc", intrPc, 0);
    check("rst_pending", pending, 0);
    rst = 1'b1;
    tick();
    check("idle_intr", intr, 0);

    // Single request on irq[1]
    irq = 4'b0010; tick(); irq = '0;
    check("t1_pending", pending, 5'b00100);
    check("t1_intr_lo", intr, 0);
    tick();
    check("t1_intr_hi", intr, 1);
    check("t1_code", intrCode, 3);
    tick();
    check("t1_intr_1cyc", intr, 0);
    check("t1_pc", intrPc, 32'h40);
    check("t1_code_held", intrCode, 3);
    tick();
    check("t1_svc_intr", intr, 0);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t1_clr_code", intrCode, 0);
    check("t1_clr_pending", pending, 0);
    tick();
    check("t1_after_intr", intr, 0);
    $display("txn1 irq[1] code=3 pc=40 done");

    // Simultaneous irq[0] and irq[2]
    irq = 4'b0101; tick(); irq = '0;
    check("t2_pending", pending, 5'b01010);
    tick();
    check("t2_intr", intr, 1);
    check("t2_code_first", intrCode, 2);
    tick();
    check("t2_ack", intr, 0);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t2_pending_left", pending, 5'b01000);
    check("t2_code_none", intrCode, 0);
    check("t2_intr_lo", intr, 0);
    tick();
    check("t2_intr_again", intr, 1);
    check("t2_code_second", intrCode, 4);
    tick();
    check("t2_pc", intrPc, 32'h40);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t2_pending_clr", pending, 0);
    $display("txn2 irq[0]+irq[2] codes 2 then 4 done");

    // Re-request in the clearing cycle
    pc = 32'h44;
    irq = 4'b0010; tick(); irq = '0;
    tick(); tick();
    check("t3_svc_code", intrCode, 3);
    clearIntr = 1'b1; irq = 4'b0010; tick(); clearIntr = 1'b0; irq = '0;
    check("t3_set_wins", pending, 5'b00100);
    check("t3_code_none", intrCode, 0);
    tick();
    check("t3_reraise", intr, 1);
    check("t3_recode", intrCode, 3);
    tick();
    check("t3_pc", intrPc, 32'h44);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t3_pending_clr", pending, 0);
    $display("txn3 set-wins-over-clear code=3 done");

    // Reset in the middle of service
    pc = 32'h80;
    irq = 4'b0001; tick(); irq = '0;
    tick(); tick();
    check("t4_svc_code", intrCode, 2);
    check("t4_svc_pc", intrPc, 32'h80);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t4_rst_intr", intr, 0);
    check("t4_rst_code", intrCode, 0);
    check("t4_rst_pc", intrPc, 0);
    check("t4_rst_pending", pending, 0);
    tick();
    check("t4_idle", intr, 0);
    irq = 4'b0100; tick(); irq = '0;
    tick();
    check("t4_new_intr", intr, 1);
    check("t4_new_code", intrCode, 4);
    tick();
    check("t4_new_pc", intrPc, 32'h80);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t4_new_clr", pending, 0);
    $display("txn4 reset mid-service then code=4 done");

`ifdef TIMER_INTR_EN
    // Quantum expiry
    pc = 32'h100;
    userMode = 1'b1; tick(); userMode = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    check("t5_not_yet", pending, 0);
    tick();
    check("t5_expire", pending, 5'b00001);
    tick();
    check("t5_intr", intr, 1);
    check("t5_code", intrCode, 1);
    tick();
    check("t5_pc", intrPc, 32'h100);
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
    check("t5_clr", pending, 0);
    $display("txn5 quantum expiry code=1 done");

    // kernelMode cancels the quantum
    userMode = 1'b1; tick(); userMode = 1'b0;
    tick(); tick();
    kernelMode = 1'b1; tick(); kernelMode = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (intr || pending[0]) hits++;
    end
    check("t6_no_timer", hits, 0);
    $display("txn6 kernelMode disarm done");
`else
    // Timer compiled out: userMode must have no effect
    userMode = 1'b1; tick(); userMode = 1'b0;
    hits = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (intr || pending[0]) hits++;
    end
    check("t5_no_timer", hits, 0);
    check("t5_pending0", pending, 0);
    $display("txn5 timer disabled build, 2000 idle cycles done");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
